// File: rtl/ysyx_25030093_sram.sv
// AXI4-Lite-style memory responder with a programmable response latency.
// One read or write is in flight at a time; reads win arbitration in IDLE.
module ysyx_25030093_sram #(
  parameter int unsigned DEPTH   = 4096,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam logic [3:0]  LAT  = 4'(LATENCY);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [31:0] mem [DEPTH];

  logic          rdHs, wrHs, enterRd, enterWr, memWe, inRange;
  logic [31:0]   curAddr, curWdata, offset;
  logic [3:0]    curStrb;
  logic [AW-1:0] idx;

  assign arready = (state_q == IDLE);
  assign rdHs    = arready && arvalid;
  assign wrHs    = arready && !arvalid && awvalid && wvalid;
  assign awready = wrHs;
  assign wready  = wrHs;

  assign rvalid = (state_q == RD_RESP);
  assign bvalid = (state_q == WR_RESP);
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign bresp  = bresp_q;

  // With zero latency the array is touched in the handshake cycle itself, so the live bus values are used.
  assign curAddr  = (state_q != IDLE) ? addr_q : (arvalid ? araddr : awaddr);
  assign curWdata = (state_q != IDLE) ? wdata_q : wdata;
  assign curStrb  = (state_q != IDLE) ? wstrb_q : wstrb;
  assign offset   = curAddr - BASE;
  assign inRange  = (offset < SPAN);
  assign idx      = offset[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    bresp_d = bresp_q;
    enterRd = 1'b0;
    enterWr = 1'b0;
    memWe   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdHs) begin
          addr_d = araddr;
          cnt_d  = LAT;
          if (LAT == 4'd0) enterRd = 1'b1;
          else             state_d = RD_WAIT;
        end else if (wrHs) begin
          addr_d  = awaddr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          cnt_d   = LAT;
          if (LAT == 4'd0) enterWr = 1'b1;
          else             state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) enterRd = 1'b1;
      end
      WR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) enterWr = 1'b1;
      end
      RD_RESP: if (rready) state_d = IDLE;
      WR_RESP: if (bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enterRd) begin
      state_d = RD_RESP;
      rdata_d = inRange ? mem[idx] : 32'd0;
      rresp_d = inRange ? OKAY : SLVERR;
    end
    if (enterWr) begin
      state_d = WR_RESP;
      memWe   = inRange;
      bresp_d = inRange ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      rresp_q <= 2'b00;
      bresp_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
    end
  end

  // The array is never cleared; the reset gate only stops a zero-latency write slipping through during reset.
  always_ff @(posedge clk) begin
    if (memWe && rst) begin
      for (int b = 0; b < 4; b++) begin
        if (curStrb[b]) mem[idx][8*b +: 8] <= curWdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_sram.sv
// Self-checking bench: a byte-addressed reference memory predicts every response of the SRAM responder.
// A second instance with a longer latency is used for the reset-during-transaction scenarios.
module tb_ysyx_25030093_sram;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LAT   = 2;
  localparam int          LATB  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  logic        rstB, arvalidB, arreadyB, rvalidB, rreadyB, awvalidB, awreadyB, wvalidB, wreadyB, bvalidB, breadyB;
  logic [31:0] araddrB, rdataB, awaddrB, wdataB;
  logic [1:0]  rrespB, brespB;
  logic [3:0]  wstrbB;

  int checks = 0;
  int errors = 0;

  logic [7:0] memBytes [int unsigned];

  ysyx_25030093_sram #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  ysyx_25030093_sram #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LATB)) dutB (
    .clk(clk), .rst(rstB),
    .araddr(araddrB), .arvalid(arvalidB), .arready(arreadyB),
    .rdata(rdataB), .rresp(rrespB), .rvalid(rvalidB), .rready(rreadyB),
    .awaddr(awaddrB), .awvalid(awvalidB), .awready(awreadyB),
    .wdata(wdataB), .wstrb(wstrbB), .wvalid(wvalidB), .wready(wreadyB),
    .bresp(brespB), .bvalid(bvalidB), .bready(breadyB)
  );

  function automatic bit inRangeM(logic [31:0] a);
    return ({32'd0, a} >= {32'd0, BASE}) && ({32'd0, a} < {32'd0, BASE} + 64'(4 * DEPTH));
  endfunction

  function automatic void modelWrite(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    if (!inRangeM(a)) return;
    for (int b = 0; b < 4; b++)
      if (s[b]) memBytes[{a[31:2], 2'b00} - BASE + b] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] modelRead(logic [31:0] a);
    logic [31:0] w;
    w = 32'd0;
    if (!inRangeM(a)) return w;
    for (int b = 0; b < 4; b++) begin
      int unsigned k;
      k = {a[31:2], 2'b00} - BASE + b;
      w[8*b +: 8] = memBytes.exists(k) ? memBytes[k] : 8'hxx;
    end
    return w;
  endfunction

  // Transaction helpers start and end 1 time unit after a rising edge; lat counts cycles from handshake to valid.
  task automatic axiWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    int n;
    n = 0; lat = -1; resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin
      checks++; errors++; $display("[TB] FAIL aw_timeout got awready=%b required 1", awready);
      awvalid = 1'b0; wvalid = 1'b0; @(posedge clk); #1; return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; awaddr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bvalid && lat < 50);
    if (!bvalid) begin
      checks++; errors++; $display("[TB] FAIL b_timeout got bvalid=%b required 1", bvalid);
    end
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic axiRead(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
    int n;
    n = 0; lat = -1; resp = 2'bxx; d = 32'hx;
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin
      checks++; errors++; $display("[TB] FAIL ar_timeout got arready=%b required 1", arready);
      arvalid = 1'b0; @(posedge clk); #1; return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0; araddr = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rvalid && lat < 50);
    if (!rvalid) begin
      checks++; errors++; $display("[TB] FAIL r_timeout got rvalid=%b required 1", rvalid);
    end
    d = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rstB = 1'b0;
    arvalid = 0; awvalid = 0; wvalid = 0; rready = 1; bready = 1;
    araddr = 0; awaddr = 0; wdata = 0; wstrb = 0;
    arvalidB = 0; awvalidB = 0; wvalidB = 0; rreadyB = 1; breadyB = 1;
    araddrB = 0; awaddrB = 0; wdataB = 0; wstrbB = 0;
    #12;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rvalid got %b required 0", rvalid); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_bvalid got %b required 0", bvalid); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL rst_rdata got %h required 0", rdata); end
    checks++; if ({rresp, bresp} !== 4'd0) begin errors++; $display("[TB] FAIL rst_resp got %b required 0000", {rresp, bresp}); end
    checks++; if (arready !== 1'b1) begin errors++; $display("[TB] FAIL rst_arready got %b required 1", arready); end
    checks++; if ({awready, wready} !== 2'b00) begin errors++; $display("[TB] FAIL rst_awready_idle got %b required 00", {awready, wready}); end
    awvalid = 1; wvalid = 1; #1;
    checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("[TB] FAIL rst_awready_req got %b required 11", {awready, wready}); end
    arvalid = 1; #1;
    checks++; if ({awready, wready} !== 2'b00) begin errors++; $display("[TB] FAIL rst_awready_rdwins got %b required 00", {awready, wready}); end
    arvalid = 0; awvalid = 0; wvalid = 0;
    @(negedge clk); rst = 1'b1; rstB = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [1:0] r; logic [31:0] d; int lat;
    axiWrite(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
    modelWrite(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    checks++; if (lat !== LAT + 1) begin errors++; $display("[TB] FAIL wr_latency got %0d required %0d", lat, LAT + 1); end
    checks++; if (r !== 2'b00) begin errors++; $display("[TB] FAIL wr_bresp got %b required 00", r); end
    axiRead(32'h8000_0010, d, r, lat);
    checks++; if (lat !== LAT + 1) begin errors++; $display("[TB] FAIL rd_latency got %0d required %0d", lat, LAT + 1); end
    checks++; if (d !== modelRead(32'h8000_0010)) begin errors++; $display("[TB] FAIL rd_data got %h required %h", d, modelRead(32'h8000_0010)); end
    checks++; if (r !== 2'b00) begin errors++; $display("[TB] FAIL rd_rresp got %b required 00", r); end
  endtask

  task automatic test_partial_strobe();
    logic [1:0] r; logic [31:0] d; int lat;
    axiWrite(32'h8000_0020, 32'h1122_3344, 4'hF, r, lat); modelWrite(32'h8000_0020, 32'h1122_3344, 4'hF);
    axiWrite(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, r, lat); modelWrite(32'h8000_0020, 32'hAABB_CCDD, 4'b0101);
    checks++; if (r !== 2'b00) begin errors++; $display("[TB] FAIL strb_bresp got %b required 00", r); end
    axiWrite(32'h8000_0020, 32'h0, 4'b0000, r, lat);
    checks++; if (r !== 2'b00) begin errors++; $display("[TB] FAIL strb0_bresp got %b required 00", r); end
    axiRead(32'h8000_0022, d, r, lat);
    checks++; if (d !== modelRead(32'h8000_0020) || d !== 32'h11BB_33DD) begin
      errors++; $display("[TB] FAIL strb_data got %h required %h", d, modelRead(32'h8000_0020)); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [31:0] d; int lat;
    logic [31:0] top, past;
    top = BASE + 32'(4 * DEPTH) - 32'd4;
    past = BASE + 32'(4 * DEPTH);
    axiWrite(BASE, 32'h0BAD_F00D, 4'hF, r, lat); modelWrite(BASE, 32'h0BAD_F00D, 4'hF);
    axiWrite(top, 32'h5A5A_A5A5, 4'hF, r, lat); modelWrite(top, 32'h5A5A_A5A5, 4'hF);
    checks++; if (r !== 2'b00) begin errors++; $display("[TB] FAIL top_bresp got %b required 00", r); end
    axiRead(32'h7FFF_FFFC, d, r, lat);
    checks++; if (r !== 2'b10) begin errors++; $display("[TB] FAIL oor_rresp got %b required 10", r); end
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL oor_rdata got %h required 0", d); end
    axiWrite(past, 32'hFFFF_FFFF, 4'hF, r, lat); modelWrite(past, 32'hFFFF_FFFF, 4'hF);
    checks++; if (r !== 2'b10) begin errors++; $display("[TB] FAIL oor_bresp got %b required 10", r); end
    axiWrite(32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, r, lat); modelWrite(32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF);
    checks++; if (r !== 2'b10) begin errors++; $display("[TB] FAIL oor_hi_bresp got %b required 10", r); end
    axiRead(BASE, d, r, lat);
    checks++; if (d !== modelRead(BASE)) begin errors++; $display("[TB] FAIL oor_word0 got %h required %h", d, modelRead(BASE)); end
    axiRead(top, d, r, lat);
    checks++; if (d !== modelRead(top) || r !== 2'b00) begin errors++; $display("[TB] FAIL oor_top got %h/%b required %h/00", d, r, modelRead(top)); end
  endtask

  task automatic test_random();
    logic [1:0] r; logic [31:0] d, a, v; logic [3:0] s; int lat;
    for (int i = 0; i < 16; i++) begin
      a = 32'h8000_0100 + 32'(4 * i); v = $urandom;
      axiWrite(a, v, 4'hF, r, lat); modelWrite(a, v, 4'hF);
    end
    for (int i = 0; i < 40; i++) begin
      a = 32'h8000_0100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        v = $urandom; s = 4'($urandom);
        axiWrite(a, v, s, r, lat); modelWrite(a, v, s);
        checks++; if (r !== 2'b00 || lat !== LAT + 1) begin errors++; $display("[TB] FAIL rand_wr got %b/%0d required 00/%0d", r, lat, LAT + 1); end
      end else begin
        axiRead(a, d, r, lat);
        checks++; if (d !== modelRead(a) || r !== 2'b00) begin errors++; $display("[TB] FAIL rand_rd addr %h got %h/%b required %h/00", a, d, r, modelRead(a)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0; int n;
    rready = 1'b0;
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(negedge clk);
    checks++; if (arready !== 1'b1) begin errors++; $display("[TB] FAIL bp_arready_idle got %b required 1", arready); end
    @(posedge clk); #1;
    araddr = 32'h8000_0020;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    d0 = rdata;
    checks++; if (d0 !== modelRead(32'h8000_0010)) begin errors++; $display("[TB] FAIL bp_data got %h required %h", d0, modelRead(32'h8000_0010)); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_hold cycle %0d got rvalid=%b rdata=%h arready=%b required 1/%h/0", i, rvalid, rdata, arready, d0); end
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got rvalid=%b arready=%b required 0/1", rvalid, arready); end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    checks++; if (rdata !== modelRead(32'h8000_0020) || n !== LAT + 1) begin
      errors++; $display("[TB] FAIL bp_second got %h after %0d required %h after %0d", rdata, n, modelRead(32'h8000_0020), LAT + 1); end
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    logic [1:0] r; logic [31:0] d, oldV, newV; int n, lat;
    oldV = modelRead(32'h8000_0010); newV = $urandom;
    araddr = 32'h8000_0010; awaddr = 32'h8000_0010; wdata = newV; wstrb = 4'hF;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    checks++; if ({arready, awready, wready} !== 3'b100) begin errors++; $display("[TB] FAIL sim_arb got %b required 100", {arready, awready, wready}); end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    checks++; if (rdata !== oldV || awready !== 1'b0) begin errors++; $display("[TB] FAIL sim_read got %h awready=%b required %h/0", rdata, awready, oldV); end
    @(posedge clk);
    @(negedge clk);
    checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("[TB] FAIL sim_wr_accept got %b required 11", {awready, wready}); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; modelWrite(32'h8000_0010, newV, 4'hF);
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("[TB] FAIL sim_bresp got %b/%b required 1/00", bvalid, bresp); end
    @(posedge clk); #1;
    axiRead(32'h8000_0010, d, r, lat);
    checks++; if (d !== modelRead(32'h8000_0010)) begin errors++; $display("[TB] FAIL sim_newdata got %h required %h", d, modelRead(32'h8000_0010)); end
  endtask

  task automatic test_reset_mid_write();
    int n;
    awaddrB = 32'h8000_0040; wdataB = 32'hCAFE_0001; wstrbB = 4'hF; awvalidB = 1'b1; wvalidB = 1'b1;
    @(posedge clk); #1;
    awvalidB = 1'b0; wvalidB = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalidB && n < 50);
    checks++; if (n !== LATB + 1 || brespB !== 2'b00) begin errors++; $display("[TB] FAIL rb_first got lat %0d bresp %b required %0d/00", n, brespB, LATB + 1); end
    @(posedge clk); #1;
    awaddrB = 32'h8000_0040; wdataB = 32'h1234_5678; awvalidB = 1'b1; wvalidB = 1'b1;
    @(posedge clk); #1;
    awvalidB = 1'b0; wvalidB = 1'b0;
    @(negedge clk);
    rstB = 1'b0; #1;
    checks++; if (rvalidB !== 1'b0 || bvalidB !== 1'b0) begin errors++; $display("[TB] FAIL rb_drop got %b/%b required 0/0", rvalidB, bvalidB); end
    @(posedge clk); @(negedge clk);
    rstB = 1'b1;
    @(negedge clk);
    checks++; if (arreadyB !== 1'b1) begin errors++; $display("[TB] FAIL rb_arready got %b required 1", arreadyB); end
    repeat (5) @(posedge clk);
    #1;
    rreadyB = 1'b0; araddrB = 32'h8000_0040; arvalidB = 1'b1;
    @(posedge clk); #1;
    arvalidB = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalidB && n < 50);
    checks++; if (rdataB !== 32'hCAFE_0001 || rrespB !== 2'b00) begin errors++; $display("[TB] FAIL rb_unchanged got %h/%b required cafe0001/00", rdataB, rrespB); end
    rstB = 1'b0; #1;
    checks++; if (rvalidB !== 1'b0 || rdataB !== 32'd0) begin errors++; $display("[TB] FAIL rb_rd_drop got %b/%h required 0/0", rvalidB, rdataB); end
    @(posedge clk); @(negedge clk);
    rstB = 1'b1; rreadyB = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_out_of_range();
    test_random();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_sram.md
# ysyx_25030093_sram

Memory responder for the ysyx_25030093 core's bus: an AXI4-Lite-style slave backed by an internal word array. It sits at the far end of the IFU instruction-fetch and LSU load/store request paths and answers one transaction at a time. A programmable access latency lets the core's valid/ready handshakes be exercised under realistic delay.

## Interface

Parameters:
- DEPTH, 4096 — number of 32-bit words in the array (power of two).
- BASE, 32'h8000_0000 — byte address of word 0.
- LATENCY, 2 — wait cycles between address acceptance and response (0..15).

Ports:
- clk  in  1  — single clock, all state on rising edge.
- rst  in  1  — asynchronous, active-low reset.
- araddr  in  32  — read byte address.
- arvalid  in  1  — read address valid.
- arready  out  1  — read address ready.
- rdata  out  32  — read data.
- rresp  out  2  — 2'b00 OKAY, 2'b10 SLVERR.
- rvalid  out  1  — read response valid.
- rready  in  1  — read response ready.
- awaddr  in  32  — write byte address.
- awvalid  in  1  — write address valid.
- awready  out  1  — write address ready.
- wdata  in  32  — write data.
- wstrb  in  4  — byte enables, bit i covers wdata[8i+7:8i].
- wvalid  in  1  — write data valid.
- wready  out  1  — write data ready.
- bresp  out  2  — write response, same encoding as rresp.
- bvalid  out  1  — write response valid.
- bready  in  1  — write response ready.

## Operation

- States: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP. Only one transaction in flight.
- arready = (state==IDLE). awready = wready = (state==IDLE) && !arvalid && awvalid && wvalid. A write is accepted only with AW and W together in the same cycle.
- Arbitration in IDLE: read wins. If arvalid and awvalid/wvalid are all high, the read is taken and the write waits.
- Address capture on handshake: the captured address, wdata and wstrb are held internally. Bus inputs may change afterwards.
- In range: BASE <= addr < BASE+4*DEPTH. Word index = (addr-BASE)[log2(DEPTH)+1:2]. addr[1:0] is ignored (aligned word access).
- IDLE to RD_WAIT / WR_WAIT on handshake, with the latency counter loaded with LATENCY. The counter decrements each cycle. The WAIT state exits to RESP when the counter reaches 0. With LATENCY=0, the block goes directly from IDLE to RESP.
- Read: on entry to RD_RESP, rdata is loaded with mem[index] and rresp=OKAY. Out of range: rdata=0, rresp=SLVERR.
- Write: on entry to WR_RESP, the bytes of mem[index] selected by wstrb are updated and bresp=OKAY. Out of range: no array change, bresp=SLVERR. wstrb=0 is a legal no-op with OKAY.
- RD_RESP holds rvalid=1 with rdata/rresp stable until rready. Then the block returns to IDLE. WR_RESP behaves the same with bvalid/bready.
- Array contents are not cleared by reset and are undefined until written (simulation may preload).

## Timing

- Reset (rst low, asynchronous): state=IDLE, counter=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0. arready is 1 in IDLE. awready and wready follow their IDLE equation.
- Reset mid-transaction: pending response dropped. A write still in WR_WAIT is not performed. A write already in WR_RESP has updated the array.
- Handshake in cycle T: rvalid/bvalid first high in cycle T+1+LATENCY.
- Response handshake in cycle R (valid&&ready): valid low and arready high in R+1. Minimum spacing between back-to-back transactions is LATENCY+2 cycles.
- arready, awready and wready are 0 in every non-IDLE state. Requests presented then are stalled, not dropped.
- Combinational paths from inputs to outputs: awvalid, wvalid and arvalid to awready/wready only. No other combinational path.

## Test plan

- Write then read, LATENCY=2: write 0x8000_0010 data 0xDEAD_BEEF strb 4'hF, then read 0x8000_0010. Required: bvalid in T+3, bresp=0, rdata=0xDEAD_BEEF, rresp=0.
- Partial strobe: word holds 0x1122_3344; write 0xAABB_CCDD strb 4'b0101. Required: read returns 0x11BB_33DD.
- Out of range: read 0x7FFF_FFFC and write 0x8000_0000+4*DEPTH. Required: rresp=2'b10 with rdata=0, bresp=2'b10, and no array word changed.
- Back-pressure: hold rready=0 for 5 cycles after rvalid. Required: rvalid and rdata stable throughout, arready=0, and a new arvalid is not accepted until one cycle after rready.
- Simultaneous requests: arvalid, awvalid and wvalid high in the same IDLE cycle. Required: read serviced first with old data. Write accepted in the first IDLE cycle after the read response, and a subsequent read returns the new data.
- Reset mid-write: drop rst during WR_WAIT with LATENCY=3. Required: rvalid=bvalid=0 immediately, array word unchanged, and arready=1 after rst rises.
